// File: rtl/alu_operand_sequencer_pkg.sv
// alu_operand_sequencer_pkg: shared widths, ALU opcodes and sequencer FSM encoding.
package alu_operand_sequencer_pkg;

    localparam int AOS_AW   = 12;
    localparam int AOS_DW   = 19;
    localparam int AOS_NREG = 8;
    localparam int AOS_SELW = 3;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_DIV16 = 3'd1,
        OP_SUB   = 3'd2,
        OP_INC2  = 3'd3,
        OP_INC1  = 3'd4,
        OP_DEC1  = 3'd5,
        OP_MUL2  = 3'd6,
        OP_MUL4  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_WB    = 2'd2
    } state_e;

endpackage

// File: rtl/aos_regfile.sv
// aos_regfile: NREG x DW register file, r0 reads as zero; writeback beats an external load
// on the same register, while loads to other registers still land in the same cycle.
module aos_regfile #(
    parameter int AW   = 12,
    parameter int DW   = 19,
    parameter int NREG = 8,
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wb_en,
    input  logic [SELW-1:0] i_wb_sel,
    input  logic [DW-1:0]   i_wb_data,
    input  logic            i_ld_en,
    input  logic [SELW-1:0] i_ld_sel,
    input  logic [DW-1:0]   i_ld_data,
    input  logic [SELW-1:0] i_ra_sel,
    input  logic [SELW-1:0] i_rb_sel,
    input  logic [SELW-1:0] i_rd_sel,
    output logic [AW-1:0]   o_ra,
    output logic [DW-1:0]   o_rb,
    output logic [DW-1:0]   o_rd
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst)
                r_mem[i] <= '0;
            else if (i != 0 && i_wb_en && i_wb_sel == SELW'(i))
                r_mem[i] <= i_wb_data;
            else if (i != 0 && i_ld_en && i_ld_sel == SELW'(i))
                r_mem[i] <= i_ld_data;
        end
    end

    assign o_ra = i_ra_sel == '0 ? '0 : r_mem[i_ra_sel][AW-1:0];
    assign o_rb = i_rb_sel == '0 ? '0 : r_mem[i_rb_sel];
    assign o_rd = i_rd_sel == '0 ? '0 : r_mem[i_rd_sel];

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: register-file front end sequencing operands to the ALU and writing results back.
// Defining ALU_FLAGS_EN adds the o_z/o_z1 result flags.
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int AW   = AOS_AW,
    parameter int DW   = AOS_DW,
    parameter int NREG = AOS_NREG,
    parameter int SELW = AOS_SELW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [2:0]      i_op_in,
    input  logic [SELW-1:0] i_a_sel,
    input  logic [SELW-1:0] i_b_sel,
    input  logic [SELW-1:0] i_d_sel,
    output logic            o_busy,
    output logic            o_done,
    output logic [AW-1:0]   o_a_bus,
    output logic [DW-1:0]   o_b_bus,
    output logic [2:0]      o_op,
    input  logic [DW-1:0]   i_c_bus,
    input  logic            i_ld_en,
    input  logic [SELW-1:0] i_ld_sel,
    input  logic [DW-1:0]   i_ld_data,
    input  logic [SELW-1:0] i_rd_sel,
    output logic [DW-1:0]   o_rd_data
`ifdef ALU_FLAGS_EN
    ,
    output logic            o_z,
    output logic            o_z1
`endif
);

    state_e          r_state, w_next;
    logic            w_accept, w_wb;
    logic [SELW-1:0] r_d_lat;
    logic [DW-1:0]   r_res;
    logic            r_done;
    logic [AW-1:0]   w_ra;
    logic [DW-1:0]   w_rb;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == S_IDLE  ? (i_req ? S_DRIVE : S_IDLE) :
                 r_state == S_DRIVE ? S_WB : S_IDLE;
    end

    always_comb begin
        w_accept = r_state == S_IDLE && i_req;
        w_wb     = r_state == S_WB;
        o_busy   = r_state == S_DRIVE || r_state == S_WB;
    end

    // Operands are captured at acceptance so later loads cannot disturb the op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_a_bus <= '0;
            o_b_bus <= '0;
            o_op    <= '0;
            r_d_lat <= '0;
            r_res   <= '0;
            r_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                o_a_bus <= w_ra;
                o_b_bus <= w_rb;
                o_op    <= i_op_in;
                r_d_lat <= i_d_sel;
            end
            if (r_state == S_DRIVE)
                r_res <= i_c_bus;
            r_done <= w_wb;
        end
    end

    assign o_done = r_done;

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_z  <= 1'b0;
            o_z1 <= 1'b1;
        end else if (w_wb) begin
            o_z  <= r_res == '0;
            o_z1 <= r_res > DW'(1);
        end
    end
`endif

    aos_regfile #(
        .AW   (AW),
        .DW   (DW),
        .NREG (NREG),
        .SELW (SELW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_wb_en   (w_wb),
        .i_wb_sel  (r_d_lat),
        .i_wb_data (r_res),
        .i_ld_en   (i_ld_en),
        .i_ld_sel  (i_ld_sel),
        .i_ld_data (i_ld_data),
        .i_ra_sel  (i_a_sel),
        .i_rb_sel  (i_b_sel),
        .i_rd_sel  (i_rd_sel),
        .o_ra      (w_ra),
        .o_rb      (w_rb),
        .o_rd      (o_rd_data)
    );

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: drives the sequencer with a behavioural ALU on its buses and checks
// results against a transaction-level register model; flag checks apply when ALU_FLAGS_EN is defined.
module tb_alu_operand_sequencer;
    import alu_operand_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op_in = '0;
    logic [2:0]  a_sel = '0, b_sel = '0, d_sel = '0;
    logic        busy, done;
    logic [11:0] a_bus;
    logic [18:0] b_bus, c_bus;
    logic [2:0]  op;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_sel = '0;
    logic [18:0] ld_data = '0;
    logic [2:0]  rd_sel = '0;
    logic [18:0] rd_data;
`ifdef ALU_FLAGS_EN
    logic        z, z1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [18:0] m_reg [8];

    always #5 clk = ~clk;

    function automatic logic [18:0] alu(input logic [2:0] o, input logic [11:0] a, input logic [18:0] b);
        int unsigned av, bv, r;
        av = a;
        bv = b;
        case (o)
            OP_ADD:   r = av + bv;
            OP_DIV16: r = av / 16;
            OP_SUB:   r = av - bv;
            OP_INC2:  r = bv + 2;
            OP_INC1:  r = bv + 1;
            OP_DEC1:  r = bv - 1;
            OP_MUL2:  r = bv * 2;
            default:  r = bv * 4;
        endcase
        return r[18:0];
    endfunction

    assign c_bus = alu(op, a_bus, b_bus);

    alu_operand_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req),
        .i_op_in   (op_in),
        .i_a_sel   (a_sel),
        .i_b_sel   (b_sel),
        .i_d_sel   (d_sel),
        .o_busy    (busy),
        .o_done    (done),
        .o_a_bus   (a_bus),
        .o_b_bus   (b_bus),
        .o_op      (op),
        .i_c_bus   (c_bus),
        .i_ld_en   (ld_en),
        .i_ld_sel  (ld_sel),
        .i_ld_data (ld_data),
        .i_rd_sel  (rd_sel),
        .o_rd_data (rd_data)
`ifdef ALU_FLAGS_EN
        ,
        .o_z       (z),
        .o_z1      (z1)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ld(input logic [2:0] s, input logic [18:0] d);
        ld_en = 1'b1;
        ld_sel = s;
        ld_data = d;
        tick();
        ld_en = 1'b0;
        if (s != 0) m_reg[s] = d;
    endtask

    task automatic read_chk(input string nm, input logic [2:0] s, input logic [18:0] exp);
        rd_sel = s;
        #1;
        chk(nm, rd_data, exp);
    endtask

    task automatic issue(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
        req = 1'b1;
        op_in = o;
        a_sel = a;
        b_sel = b;
        d_sel = d;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
        logic [18:0] res;
        logic [18:0] av;
        av = m_reg[a];
        res = alu(o, av[11:0], m_reg[b]);
        issue(o, a, b, d);
        tick();
        req = 1'b0;
        chk("busy_drive", busy, 1);
        chk("a_bus", a_bus, av[11:0]);
        chk("b_bus", b_bus, m_reg[b]);
        chk("op", op, o);
        tick();
        chk("done_early", done, 0);
        tick();
        chk("done", done, 1);
        chk("busy_after", busy, 0);
        if (d != 0) m_reg[d] = res;
        read_chk("rd_result", d, m_reg[d]);
`ifdef ALU_FLAGS_EN
        chk("z", z, res == 0);
        chk("z1", z1, res > 1);
`endif
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [18:0] a_val;
        logic [18:0] b_val;
        logic [18:0] exp;
    } vec_t;

    initial begin
        vec_t vecs [9];
        int ndone;
        logic [18:0] e1, e2, tmp;
        vecs[0] = '{OP_ADD,   19'h00123, 19'h00010, 19'h00133};
        vecs[1] = '{OP_DIV16, 19'h00FF0, 19'h00000, 19'h000FF};
        vecs[2] = '{OP_SUB,   19'h00010, 19'h00123, 19'h7FEED};
        vecs[3] = '{OP_INC2,  19'h00000, 19'h7FFFF, 19'h00001};
        vecs[4] = '{OP_INC1,  19'h00000, 19'h7FFFF, 19'h00000};
        vecs[5] = '{OP_DEC1,  19'h00000, 19'h00000, 19'h7FFFF};
        vecs[6] = '{OP_MUL2,  19'h00000, 19'h40001, 19'h00002};
        vecs[7] = '{OP_MUL4,  19'h00000, 19'h12345, 19'h48D14};
        vecs[8] = '{OP_ADD,   19'h7F123, 19'h00001, 19'h00124};
        for (int i = 0; i < 8; i++) m_reg[i] = '0;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_a_bus", a_bus, 0);
        chk("rst_b_bus", b_bus, 0);
        chk("rst_op", op, 0);
`ifdef ALU_FLAGS_EN
        chk("rst_z", z, 0);
        chk("rst_z1", z1, 1);
`endif
        for (int i = 0; i < 8; i++) read_chk("rst_reg", 3'(i), 19'h0);

        for (int i = 0; i < 9; i++) begin
            do_ld(3'd1, vecs[i].a_val);
            do_ld(3'd2, vecs[i].b_val);
            run_op(vecs[i].op, 3'd1, 3'd2, 3'd3);
            read_chk("vec_const", 3'd3, vecs[i].exp);
        end

        do_ld(3'd6, 19'h7FFFF);
        run_op(OP_INC1, 3'd0, 3'd6, 3'd6);
        read_chk("inc1_wrap", 3'd6, 19'h0);

        // r0 destination plus a req held through busy: exactly one done
        do_ld(3'd2, 19'h00010);
        ndone = 0;
        issue(OP_MUL4, 3'd0, 3'd2, 3'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 2) req = 1'b0;
            if (i == 2) d_sel = 3'd4;
            ndone += int'(done);
        end
        chk("one_done", ndone, 1);
        read_chk("r0_zero", 3'd0, 19'h0);
        read_chk("r4_untouched", 3'd4, m_reg[4]);

        // writeback and external load collide on r3
        do_ld(3'd1, 19'h00200);
        e1 = alu(OP_ADD, m_reg[1][11:0], m_reg[2]);
        issue(OP_ADD, 3'd1, 3'd2, 3'd3);
        tick();
        req = 1'b0;
        tick();
        ld_en = 1'b1;
        ld_sel = 3'd3;
        ld_data = 19'h55;
        tick();
        ld_en = 1'b0;
        m_reg[3] = e1;
        chk("coll_done", done, 1);
        read_chk("wb_wins", 3'd3, e1);
        do_ld(3'd3, 19'h55);
        read_chk("ld_after", 3'd3, 19'h55);

        // load to a source register while the op is in flight
        e1 = alu(OP_ADD, m_reg[1][11:0], m_reg[2]);
        issue(OP_ADD, 3'd1, 3'd2, 3'd4);
        tick();
        req = 1'b0;
        ld_en = 1'b1;
        ld_sel = 3'd1;
        ld_data = 19'h003AB;
        tick();
        ld_en = 1'b0;
        m_reg[1] = 19'h003AB;
        tick();
        m_reg[4] = e1;
        read_chk("inflight_res", 3'd4, e1);
        read_chk("inflight_ld", 3'd1, 19'h003AB);

        // back-to-back: req during done reads the just-written register
        e1 = alu(OP_ADD, m_reg[1][11:0], m_reg[2]);
        issue(OP_ADD, 3'd1, 3'd2, 3'd5);
        tick();
        req = 1'b0;
        tick();
        tick();
        m_reg[5] = e1;
        chk("b2b_done", done, 1);
        tmp = m_reg[5];
        e2 = alu(OP_SUB, tmp[11:0], m_reg[5]);
        issue(OP_SUB, 3'd5, 3'd5, 3'd6);
        tick();
        req = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_a_fwd", a_bus, tmp[11:0]);
        chk("b2b_b_fwd", b_bus, e1);
        tick();
        tick();
        m_reg[6] = e2;
        chk("b2b_done2", done, 1);
        read_chk("b2b_res", 3'd6, e2);

        // reset while in DRIVE aborts the op
        do_ld(3'd1, 19'h00321);
        issue(OP_ADD, 3'd1, 3'd2, 3'd7);
        tick();
        req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        chk("abort_busy", busy, 0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            ndone += int'(done);
        end
        chk("abort_no_done", ndone, 0);
        read_chk("abort_dest", 3'd7, 19'h0);
        read_chk("abort_src", 3'd1, 19'h0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(1, 0) == 1)
                do_ld(3'($urandom_range(7, 0)), 19'($urandom));
            run_op(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                   3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
        end
        for (int i = 0; i < 8; i++) read_chk("final_reg", 3'(i), m_reg[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
